// File: rtl/digit_serial_add_sub.sv
// Digit-serial adder/subtractor, LSD first, framed in words of
// WORD_DIGITS digits with end-of-word carry and overflow flags.
module digit_serial_add_sub #(
  parameter int DIGIT_W     = 1,
  parameter int WORD_DIGITS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_first,
  input  logic               sub,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               out_valid,
  output logic [DIGIT_W-1:0] out_sum,
  output logic               out_last,
  output logic               carry_out,
  output logic               overflow,
  output logic               err
);

  localparam int CW = (WORD_DIGITS > 2) ? $clog2(WORD_DIGITS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WORD_DIGITS - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               mode_q, mode_d;
  logic               out_valid_q, out_valid_d;
  logic [DIGIT_W-1:0] out_sum_q, out_sum_d;
  logic               out_last_q, out_last_d;
  logic               carry_out_q, carry_out_d;
  logic               overflow_q, overflow_d;
  logic               err_q, err_d;

  logic               accept;
  logic               last;
  logic               mode_eff;
  logic [CW-1:0]      idx;
  logic [DIGIT_W-1:0] b_eff;
  logic [DIGIT_W-1:0] s;
  logic [DIGIT_W:0]   c;

  // in_first restarts the word from any state
  always_comb begin
    accept   = in_valid & (in_first | (state_q == ACTIVE));
    mode_eff = in_first ? sub : mode_q;
    idx      = in_first ? '0 : cnt_q;
    last     = accept & (idx == LAST_IDX);
    b_eff    = mode_eff ? ~b : b;
    s        = '0;
    c        = '0;
    c[0]     = in_first ? sub : carry_q;
    for (int i = 0; i < DIGIT_W; i++) begin
      s[i]   = a[i] ^ b_eff[i] ^ c[i];
      c[i+1] = (a[i] & b_eff[i]) | (c[i] & (a[i] ^ b_eff[i]));
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    mode_d      = mode_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    out_valid_d = accept;
    out_last_d  = last;
    out_sum_d   = accept ? s : out_sum_q;
    err_d       = in_valid & ~in_first & (state_q == IDLE);
    if (accept) begin
      mode_d  = mode_eff;
      carry_d = c[DIGIT_W];
      if (last) begin
        state_d     = IDLE;
        cnt_d       = '0;
        carry_out_d = c[DIGIT_W];
        overflow_d  = c[DIGIT_W] ^ c[DIGIT_W-1];
      end else begin
        state_d = ACTIVE;
        cnt_d   = idx + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_last_q  <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_last_q  <= out_last_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_last  = out_last_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign err       = err_q;

endmodule

// File: tb/tb_digit_serial_add_sub.sv
// Scoreboard bench for digit_serial_add_sub with a word-level
// arithmetic reference model (4-bit digits, 4-digit words).
module tb_digit_serial_add_sub;

  localparam int DW = 4;
  localparam int WD = 4;
  localparam int WW = DW * WD;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_first = 1'b0;
  logic          sub = 1'b0;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic          out_valid;
  logic [DW-1:0] out_sum;
  logic          out_last;
  logic          carry_out;
  logic          overflow;
  logic          err;

  digit_serial_add_sub #(.DIGIT_W(DW), .WORD_DIGITS(WD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first),
    .sub(sub), .a(a), .b(b), .out_valid(out_valid), .out_sum(out_sum),
    .out_last(out_last), .carry_out(carry_out), .overflow(overflow),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    bit [DW-1:0] sum;
    bit          last;
    bit          cout;
    bit          ovf;
  } exp_t;

  exp_t q[$];
  bit   m_cout = 1'b0;
  bit   m_ovf  = 1'b0;
  bit   active = 1'b0;
  bit   mon_en = 1'b1;
  int   tests  = 0;
  int   fails  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && rst && (out_valid || err)) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got valid=%0b err=%0b expected none",
                 out_valid, err);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("err", err, e.is_err);
        chk("out_valid", out_valid, !e.is_err);
        if (!e.is_err) begin
          chk("out_sum", out_sum, e.sum);
          chk("out_last", out_last, e.last);
        end
        chk("carry_out", carry_out, e.cout);
        chk("overflow", overflow, e.ovf);
      end
    end
  end

  task automatic step(input bit v, input bit f, input bit s,
                      input logic [DW-1:0] da, input logic [DW-1:0] db);
    in_valid = v;
    in_first = f;
    sub      = s;
    a        = da;
    b        = db;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  // Word-level reference: whole-word two's-complement arithmetic
  task automatic send_word(input logic [WW-1:0] wa, input logic [WW-1:0] wb,
                           input bit s, input int ndig, input int maxgap);
    logic [WW-1:0] beff;
    logic [WW:0]   full;
    exp_t          e;
    beff = s ? ~wb : wb;
    full = {1'b0, wa} + {1'b0, beff} + (WW+1)'(s);
    for (int k = 0; k < ndig; k++) begin
      if (k != 0) begin
        repeat ($urandom_range(0, maxgap)) step(0, 0, 1'($urandom), '0, '0);
      end
      e.is_err = 1'b0;
      e.sum    = full[k*DW +: DW];
      e.last   = (k == WD - 1);
      if (e.last) begin
        m_cout = full[WW];
        m_ovf  = (wa[WW-1] == beff[WW-1]) && (full[WW-1] != wa[WW-1]);
      end
      e.cout = m_cout;
      e.ovf  = m_ovf;
      q.push_back(e);
      step(1, k == 0, (k == 0) ? s : 1'($urandom),
           wa[k*DW +: DW], wb[k*DW +: DW]);
    end
    active = (ndig < WD);
  endtask

  task automatic send_err();
    exp_t e;
    e.is_err = 1'b1;
    e.sum    = '0;
    e.last   = 1'b0;
    e.cout   = m_cout;
    e.ovf    = m_ovf;
    q.push_back(e);
    step(1, 0, 1'($urandom), DW'($urandom), DW'($urandom));
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", q.size(), 0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_out_valid"}, out_valid, 0);
    chk({nm, "_out_sum"}, out_sum, 0);
    chk({nm, "_out_last"}, out_last, 0);
    chk({nm, "_carry_out"}, carry_out, 0);
    chk({nm, "_overflow"}, overflow, 0);
    chk({nm, "_err"}, err, 0);
  endtask

  initial begin
    #3;
    chk_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(0, 0, 0, '0, '0);

    send_word(16'h1234, 16'h0FCD, 0, WD, 0);
    send_word(16'h0005, 16'h0007, 1, WD, 0);
    send_word(16'h7FFF, 16'h0001, 0, WD, 0);
    send_word(16'hFFFF, 16'h0001, 0, 1, 0);
    for (int k = 1; k < WD; k++) begin
      exp_t e;
      repeat (2) step(0, 0, 0, '0, '0);
      e.is_err = 1'b0;
      e.sum    = '0;
      e.last   = (k == WD - 1);
      if (e.last) begin
        m_cout = 1'b1;
        m_ovf  = 1'b0;
      end
      e.cout = m_cout;
      e.ovf  = m_ovf;
      q.push_back(e);
      step(1, 0, 0, (k == 0) ? 4'hF : 4'hF, 4'h0);
    end
    active = 1'b0;
    send_word(16'h4321, 16'h1111, 0, 2, 0);
    send_word(16'h0001, 16'h0001, 0, WD, 0);
    send_err();
    step(0, 0, 0, '0, '0);
    send_word(16'hABCD, 16'h1234, 1, 3, 1);
    send_word(16'h8000, 16'h0001, 1, WD, 0);
    drain();

    for (int n = 0; n < 80; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0 && !active) send_err();
      else if (r == 1)
        send_word(16'($urandom), 16'($urandom), 1'($urandom),
                  $urandom_range(1, WD - 1), 2);
      else
        send_word(16'($urandom), 16'($urandom), 1'($urandom), WD,
                  (r < 5) ? 0 : 2);
    end
    send_word(16'hFFFF, 16'h8000, 0, WD, 0);
    drain();
    chk("flags_set_cout", carry_out, 1);
    chk("flags_set_ovf", overflow, 1);

    mon_en = 1'b0;
    step(1, 1, 0, 4'h3, 4'h4);
    in_valid = 1'b1;
    a        = 4'h5;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_zero("async_reset");
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst    = 1'b1;
    q.delete();
    m_cout = 1'b0;
    m_ovf  = 1'b0;
    active = 1'b0;
    @(negedge clk);
    #1;
    mon_en = 1'b1;
    send_err();
    send_word(16'h0003, 16'h0001, 0, WD, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/digit_serial_add_sub.md
Name: digit_serial_add_sub

Overview:
- Parametrised digit-serial adder/subtractor: consumes operands DIGIT_W bits per cycle, least-significant digit first, in words of WORD_DIGITS digits.
- Generalises the 1-bit serial adder with configurable digit width, word framing, add/subtract mode, valid-qualified gaps, and end-of-word carry/overflow flags.
- Sits in the sequential-arithmetic datapath library, feeding serial links and bit/digit-serial MAC experiments.

Parameters:
- DIGIT_W, 1, operand/result bits processed per accepted cycle (>=1).
- WORD_DIGITS, 16, digits per word (>=2); word width = DIGIT_W*WORD_DIGITS.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- in_valid  input  1  a/b/in_first/sub are valid this cycle.
- in_first  input  1  marks the least-significant digit of a new word.
- sub  input  1  mode, sampled only on accepted in_first: 0 = a+b, 1 = a-b.
- a  input  DIGIT_W  operand A digit.
- b  input  DIGIT_W  operand B digit.
- out_valid  output  1  out_sum is valid.
- out_sum  output  DIGIT_W  result digit.
- out_last  output  1  out_sum is the most-significant digit of the word.
- carry_out  output  1  final carry of the last completed word; in subtract mode 1 = no borrow.
- overflow  output  1  signed two's-complement overflow of the last completed word.
- err  output  1  one-cycle pulse: in_valid without in_first while IDLE.

Behaviour:
- Reset (rst=0, async): state IDLE; carry register 0; digit counter 0; mode register 0; all outputs 0.
- States:
  - IDLE -> ACTIVE on accepted in_first.
  - ACTIVE -> IDLE after the accepted digit with counter == WORD_DIGITS-1.
- Accepted digit: in_valid=1 and (in_first=1 or state==ACTIVE).
- Datapath:
  - Per accepted digit: b_eff = sub_mode ? ~b : b.
  - {c_next, s} = a + b_eff + c_in, computed in DIGIT_W+1 bits.
  - c_in = (sub on this cycle) on in_first digits, otherwise the carry register.
  - Mode register loads sub on in_first and is held for the rest of the word.
- Latency: exactly 1 cycle. Outputs are registered and update on the clock edge that accepts the digit.
  - out_valid=1 the next cycle with out_sum=s.
  - out_last=1 when the accepted digit was number WORD_DIGITS-1 (0-based).
- Gaps: in_valid=0 holds carry, counter and mode. out_valid=0 that cycle; out_sum holds its last value.
- Word end, on the cycle out_last is 1:
  - carry_out = c_next of the MSB digit.
  - overflow = carry into the MSB bit XOR carry out of the MSB bit of the final digit.
  - Both are held until the next completed word; they are not updated on any other cycle.
- in_first while ACTIVE: the current word is aborted silently, with no out_last and no flag update. The new word starts with counter reset, c_in per the new sub, and that digit counted as digit 0.
- in_first on the cycle the previous word's last digit would be due: handled as an abort plus restart.
- Back-to-back words: in_first may arrive the cycle after a last digit with no bubble; full throughput of 1 digit/cycle.
- err: asserted one cycle after an in_valid=1, in_first=0 cycle in IDLE. That digit is dropped and out_valid stays 0.
- Counter: the digit counter wraps only through a word end; it never exceeds WORD_DIGITS-1.
- Reset mid-word: everything returns to the reset values immediately; a partial word is discarded.
- Operators: the carry chain uses only ^, &, |, ~ (full-adder equations), DIGIT_W-bit ripple, no `+` operator.

Test Plan:
- DIGIT_W=1, WORD_DIGITS=16, add 16'h0003 + 16'h0001 LSB-first -> serial sum 16'h0004, out_last on the 16th out_valid, carry_out=0, overflow=0.
- DIGIT_W=4, WORD_DIGITS=4, add 16'h1234 + 16'h0FCD -> out_sum digits 1,0,2,2; carry_out=0, overflow=0.
- DIGIT_W=4, WORD_DIGITS=4:
  - sub 16'h0005 - 16'h0007 -> digits E,F,F,F (16'hFFFE); carry_out=0 (borrow); overflow=0.
  - 16'h7FFF + 16'h0001 -> 16'h8000, overflow=1, carry_out=0.
- DIGIT_W=4, WORD_DIGITS=4, 16'hFFFF + 16'h0001 with in_valid=0 gaps of 2 cycles between digits -> digits 0,0,0,0; carry_out=1; out_valid only 1 cycle after each accepted digit.
- Abort and protocol error:
  - in_first mid-word after 2 digits, then a full 16'h0001 + 16'h0001 word -> no out_last for the aborted word; result 16'h0002; flags updated once.
  - in_valid with in_first=0 in IDLE -> err pulse, no out_valid.
  - rst low mid-word -> all outputs 0 asynchronously.
